// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage with a 16-bit asynchronous SRAM port. Each 32-bit word is moved as
// two halfword accesses (low half first). The pipeline is held via 'ready'
// while the access runs.
module mem_stage_sram_ctrl #(
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WB_EN_IN,
   input  logic               MEM_R_EN_IN,
   input  logic               MEM_W_EN_IN,
   input  logic [31:0]        ALU_result_IN,
   input  logic [31:0]        Val_Rm_IN,
   input  logic [3:0]         Dest_IN,
   output logic               WB_EN,
   output logic               MEM_R_EN,
   output logic [31:0]        ALU_result,
   output logic [31:0]        MEM_read_value,
   output logic [3:0]         Dest,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_OUT,
   output logic               SRAM_DQ_OE,
   input  logic [15:0]        SRAM_DQ_IN,
   output logic               SRAM_WE_N
);

   localparam int             CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(WAIT_CYCLES - 1);
   localparam logic [31:0]    BASE_L = 32'(BASE_ADDR);
   // WE_N level on the first cycle of a write phase: with a single-cycle phase
   // that cycle is also the hold cycle, so the strobe never asserts (stores
   // need WAIT_CYCLES >= 2 to actually write).
   localparam logic           WE_N_FIRST = (WAIT_CYCLES == 1);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   state_t             state_reg;
   logic [CW-1:0]      cnt_reg;
   logic [15:0]        lo_tmp_reg;
   logic [31:0]        rd_word_reg;
   logic [SRAM_AW-1:0] addr_reg;
   logic [15:0]        dq_out_reg;
   logic               oe_reg;
   logic               we_n_reg;

   logic               borrow;
   logic [SRAM_AW-2:0] word_idx;
   logic [SRAM_AW-1:0] lo_addr;
   logic [SRAM_AW-1:0] hi_addr;
   logic               cnt_last;
   logic               next_is_last;

   // Word index of (address - base), computed only over the bits that survive
   // truncation; the borrow from the ignored byte-offset bits keeps it exact.
   assign borrow   = (ALU_result_IN[1:0] < BASE_L[1:0]);
   assign word_idx = ALU_result_IN[SRAM_AW:2] - BASE_L[SRAM_AW:2]
                     - {{(SRAM_AW-2){1'b0}}, borrow};
   assign lo_addr  = {word_idx, 1'b0};
   assign hi_addr  = {word_idx, 1'b1};

   assign cnt_last     = (cnt_reg == LAST);
   assign next_is_last = ((cnt_reg + CW'(1)) == LAST);

   // Stall while a request waits in IDLE or any halfword phase is running.
   assign ready = !(((state_reg == IDLE) && (MEM_R_EN_IN || MEM_W_EN_IN)) ||
                    (state_reg == RD_LO) || (state_reg == RD_HI) ||
                    (state_reg == WR_LO) || (state_reg == WR_HI));

   assign WB_EN          = WB_EN_IN & ready;
   assign MEM_R_EN       = MEM_R_EN_IN;
   assign ALU_result     = ALU_result_IN;
   assign Dest           = Dest_IN;
   assign MEM_read_value = rd_word_reg;
   assign SRAM_ADDR      = addr_reg;
   assign SRAM_DQ_OUT    = dq_out_reg;
   assign SRAM_DQ_OE     = oe_reg;
   assign SRAM_WE_N      = we_n_reg;

   // Access sequencer; SRAM bus signals are registered for the upcoming state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         lo_tmp_reg  <= '0;
         rd_word_reg <= '0;
         addr_reg    <= '0;
         dq_out_reg  <= '0;
         oe_reg      <= 1'b0;
         we_n_reg    <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (MEM_R_EN_IN) begin
                  state_reg <= RD_LO;
                  addr_reg  <= lo_addr;
                  oe_reg    <= 1'b0;
                  we_n_reg  <= 1'b1;
               end else if (MEM_W_EN_IN) begin
                  state_reg  <= WR_LO;
                  addr_reg   <= lo_addr;
                  dq_out_reg <= Val_Rm_IN[15:0];
                  oe_reg     <= 1'b1;
                  we_n_reg   <= WE_N_FIRST;
               end else begin
                  addr_reg   <= '0;
                  dq_out_reg <= '0;
                  oe_reg     <= 1'b0;
                  we_n_reg   <= 1'b1;
               end
            end
            RD_LO: begin
               if (cnt_last) begin
                  lo_tmp_reg <= SRAM_DQ_IN;
                  cnt_reg    <= '0;
                  state_reg  <= RD_HI;
                  addr_reg   <= hi_addr;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            RD_HI: begin
               if (cnt_last) begin
                  // Publish both halves together so the visible word never mixes loads.
                  rd_word_reg <= {SRAM_DQ_IN, lo_tmp_reg};
                  cnt_reg     <= '0;
                  state_reg   <= DONE;
                  addr_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            WR_LO: begin
               if (cnt_last) begin
                  cnt_reg    <= '0;
                  state_reg  <= WR_HI;
                  addr_reg   <= hi_addr;
                  dq_out_reg <= Val_Rm_IN[31:16];
                  we_n_reg   <= WE_N_FIRST;
               end else begin
                  cnt_reg  <= cnt_reg + CW'(1);
                  we_n_reg <= next_is_last;
               end
            end
            WR_HI: begin
               if (cnt_last) begin
                  cnt_reg    <= '0;
                  state_reg  <= DONE;
                  addr_reg   <= '0;
                  dq_out_reg <= '0;
                  oe_reg     <= 1'b0;
                  we_n_reg   <= 1'b1;
               end else begin
                  cnt_reg  <= cnt_reg + CW'(1);
                  we_n_reg <= next_is_last;
               end
            end
            DONE: begin
               // Pipeline advances on this edge; never re-issue the same access.
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed cases then random loads/stores/ALU ops,
// checked against an expected-memory model and per-cycle bus expectations.
module tb_mem_stage_sram_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // DUT A: default parameters (WAIT_CYCLES = 2, 18-bit SRAM)
   logic        wb2 = 0, r2 = 0, w2 = 0;
   logic [31:0] alu2 = 0, val2 = 0;
   logic [3:0]  dest2 = 0;
   logic        wb_en2, mem_r_en2, ready2, oe2, we_n2;
   logic [31:0] alu_o2, rd_val2;
   logic [3:0]  dest_o2;
   logic [17:0] addr2;
   logic [15:0] dq_out2, dq_in2;

   // DUT B: WAIT_CYCLES = 1, 10-bit SRAM
   logic        wb1 = 0, r1 = 0, w1 = 0;
   logic [31:0] alu1 = 0, val1 = 0;
   logic [3:0]  dest1 = 0;
   logic        wb_en1, mem_r_en1, ready1, oe1, we_n1;
   logic [31:0] alu_o1, rd_val1;
   logic [3:0]  dest_o1;
   logic [9:0]  addr1;
   logic [15:0] dq_out1, dq_in1;

   mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .WB_EN_IN(wb2), .MEM_R_EN_IN(r2), .MEM_W_EN_IN(w2),
      .ALU_result_IN(alu2), .Val_Rm_IN(val2), .Dest_IN(dest2),
      .WB_EN(wb_en2), .MEM_R_EN(mem_r_en2), .ALU_result(alu_o2), .MEM_read_value(rd_val2),
      .Dest(dest_o2), .ready(ready2), .SRAM_ADDR(addr2), .SRAM_DQ_OUT(dq_out2),
      .SRAM_DQ_OE(oe2), .SRAM_DQ_IN(dq_in2), .SRAM_WE_N(we_n2));

   mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(10), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .WB_EN_IN(wb1), .MEM_R_EN_IN(r1), .MEM_W_EN_IN(w1),
      .ALU_result_IN(alu1), .Val_Rm_IN(val1), .Dest_IN(dest1),
      .WB_EN(wb_en1), .MEM_R_EN(mem_r_en1), .ALU_result(alu_o1), .MEM_read_value(rd_val1),
      .Dest(dest_o1), .ready(ready1), .SRAM_ADDR(addr1), .SRAM_DQ_OUT(dq_out1),
      .SRAM_DQ_OE(oe1), .SRAM_DQ_IN(dq_in1), .SRAM_WE_N(we_n1));

   // SRAM devices and the expected contents model
   logic [15:0] sram2 [0:262143];
   logic [15:0] exp2  [0:262143];
   logic [15:0] sram1 [0:1023];
   logic [15:0] exp1  [0:1023];
   logic [31:0] last_rd [2];

   assign dq_in2 = sram2[addr2];
   assign dq_in1 = sram1[addr1];
   always @(posedge clk) if (!we_n2 && oe2) sram2[addr2] <= dq_out2;
   always @(posedge clk) if (!we_n1 && oe1) sram1[addr1] <= dq_out1;

   // Observation mux over the two DUTs
   logic        sel = 1'b0;
   logic        o_ready, o_wb_en, o_mem_r_en, o_oe, o_we_n;
   logic [31:0] o_alu, o_rd_val, o_addr;
   logic [3:0]  o_dest;
   logic [15:0] o_dq;
   assign o_ready    = sel ? ready1    : ready2;
   assign o_wb_en    = sel ? wb_en1    : wb_en2;
   assign o_mem_r_en = sel ? mem_r_en1 : mem_r_en2;
   assign o_oe       = sel ? oe1       : oe2;
   assign o_we_n     = sel ? we_n1     : we_n2;
   assign o_alu      = sel ? alu_o1    : alu_o2;
   assign o_rd_val   = sel ? rd_val1   : rd_val2;
   assign o_addr     = sel ? {22'd0, addr1} : {14'd0, addr2};
   assign o_dest     = sel ? dest_o1   : dest_o2;
   assign o_dq       = sel ? dq_out1   : dq_out2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] exp_rd(input bit s, input int a);
      return s ? exp1[a] : exp2[a];
   endfunction

   function automatic logic [15:0] sram_rd(input bit s, input int a);
      return s ? sram1[a] : sram2[a];
   endfunction

   task automatic exp_wr(input bit s, input int a, input logic [15:0] d);
      if (s) exp1[a] = d; else exp2[a] = d;
   endtask

   task automatic drive(input bit s, input bit r, input bit w, input bit wb,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
      wb2 = s ? 1'b0 : wb;  r2 = s ? 1'b0 : r;  w2 = s ? 1'b0 : w;
      alu2 = s ? 32'd0 : alu;  val2 = s ? 32'd0 : val;  dest2 = s ? 4'd0 : dest;
      wb1 = s ? wb : 1'b0;  r1 = s ? r : 1'b0;  w1 = s ? w : 1'b0;
      alu1 = s ? alu : 32'd0;  val1 = s ? val : 32'd0;  dest1 = s ? dest : 4'd0;
   endtask

   // One instruction through the stage: returns after its DONE cycle has been checked.
   task automatic access(input bit s, input bit r, input bit w, input bit wb,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
      int wc, lo, hi, stalls, p, c;
      logic [31:0] off, e_addr;
      logic        e_we, e_oe;
      bit          done;
      wc  = s ? 1 : 2;
      off = alu - 32'd1024;
      lo  = int'(((off >> 2) * 32'd2) & (s ? 32'd1023 : 32'd262143));
      hi  = lo + 1;
      @(posedge clk); #1;
      sel = s;
      drive(s, r, w, wb, alu, val, dest);
      if (!(r || w)) begin
         @(negedge clk);
         chk("nop_ready", o_ready, 1);
         chk("nop_wb_en", o_wb_en, wb);
         chk("nop_we_n", o_we_n, 1);
         chk("nop_oe", o_oe, 0);
         chk("nop_addr", o_addr, 0);
         chk("nop_alu_pass", o_alu, alu);
         chk("nop_dest_pass", o_dest, dest);
         chk("nop_rd_hold", o_rd_val, last_rd[s]);
         $display("op=ALU dut_w=%0d alu=%h wb=%0d", wc, alu, wb);
         return;
      end
      stalls = 0;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (o_ready) begin
            done = 1;
         end else begin
            stalls++;
            chk("stall_wb_en", o_wb_en, 0);
            chk("stall_mem_r_en", o_mem_r_en, r);
            if (k == 0) begin
               e_addr = 0; e_we = 1; e_oe = 0;
            end else begin
               p = (k - 1) / wc;
               c = (k - 1) % wc;
               e_addr = (p != 0) ? hi : lo;
               if (r) begin
                  e_we = 1; e_oe = 0;
               end else begin
                  e_we = (c == wc - 1); e_oe = 1;
                  chk("wr_dq", o_dq, (p != 0) ? val[31:16] : val[15:0]);
               end
            end
            chk("bus_addr", o_addr, e_addr);
            chk("bus_we_n", o_we_n, e_we);
            chk("bus_oe", o_oe, e_oe);
         end
      end
      chk("done_reached", done, 1);
      chk("stall_cycles", stalls, 2 * wc + 1);
      if (done) begin
         chk("done_wb_en", o_wb_en, wb);
         chk("done_oe", o_oe, 0);
         chk("done_we_n", o_we_n, 1);
         if (r) begin
            last_rd[s] = {exp_rd(s, hi), exp_rd(s, lo)};
         end else begin
            exp_wr(s, lo, val[15:0]);
            exp_wr(s, hi, val[31:16]);
         end
         chk("read_value", o_rd_val, last_rd[s]);
         chk("sram_lo", sram_rd(s, lo), exp_rd(s, lo));
         chk("sram_hi", sram_rd(s, hi), exp_rd(s, hi));
      end
      $display("op=%s dut_w=%0d alu=%h lo=%0d val=%h stalls=%0d rd=%h",
               r ? "LD" : "ST", wc, alu, lo, val, stalls, o_rd_val);
   endtask

   initial begin
      logic [31:0] a, v;
      int op;
      for (int i = 0; i < 262144; i++) begin
         sram2[i] = 16'($urandom);
         exp2[i]  = sram2[i];
      end
      for (int i = 0; i < 1024; i++) begin
         sram1[i] = 16'($urandom);
         exp1[i]  = sram1[i];
      end
      sram2[2] = 16'hBEEF; exp2[2] = 16'hBEEF;
      sram2[3] = 16'hDEAD; exp2[3] = 16'hDEAD;
      last_rd[0] = 0;
      last_rd[1] = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", ready2, 1);
      chk("rst_we_n", we_n2, 1);
      chk("rst_oe", oe2, 0);
      chk("rst_addr", addr2, 0);
      chk("rst_dq_out", dq_out2, 0);
      chk("rst_rd_val", rd_val2, 0);
      #1 rst = 1'b1;
      $display("reset released");

      // Load of SRAM[2]/[3]
      access(0, 1, 0, 1, 32'd1028, 32'd0, 4'd3);
      // Store to word 2 (halfwords 4/5)
      access(0, 0, 1, 0, 32'd1032, 32'h12345678, 4'd0);
      // ALU instruction passes straight through
      access(0, 0, 0, 1, 32'h0000_0ABC, 32'd0, 4'd7);
      // Back-to-back load then store, then read it back with nonzero byte bits
      access(0, 1, 0, 1, 32'd1032, 32'd0, 4'd1);
      access(0, 0, 1, 0, 32'd1040, 32'hA5A5_5A5A, 4'd0);
      access(0, 1, 0, 1, 32'd1043, 32'd0, 4'd2);
      // Address below the base wraps to the top of the SRAM
      access(0, 0, 1, 0, 32'd0, 32'hCAFE_D00D, 4'd0);
      access(0, 1, 0, 1, 32'd0, 32'd0, 4'd4);

      // Reset in the middle of the high-half read
      @(posedge clk); #1;
      sel = 0;
      drive(0, 1, 0, 1, 32'd1028, 32'd0, 4'd5);
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_we_n", we_n2, 1);
      chk("midrst_oe", oe2, 0);
      chk("midrst_addr", addr2, 0);
      chk("midrst_rd_val", rd_val2, 0);
      chk("midrst_ready", ready2, 0);
      last_rd[0] = 0;
      last_rd[1] = 0;
      @(negedge clk);
      chk("inrst_addr", addr2, 0);
      #1 rst = 1'b1;
      drive(0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
      $display("reset pulsed during load");
      access(0, 1, 0, 1, 32'd1028, 32'd0, 4'd5);

      // WAIT_CYCLES=1 with read and write both requested: read wins
      access(1, 1, 1, 1, 32'd1044, 32'hFFFF_0000, 4'd6);
      access(1, 0, 0, 1, 32'd1044, 32'd0, 4'd6);

      // Randomized mix
      for (int t = 0; t < 40; t++) begin
         op = $urandom_range(0, 2);
         a  = ($urandom_range(0, 3) == 0) ? $urandom
              : 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         v  = $urandom;
         case (op)
            0:       access(0, 0, 0, 1'($urandom), a, v, 4'($urandom));
            1:       access(0, 1, 0, 1, a, v, 4'($urandom));
            default: access(0, 0, 1, 0, a, v, 4'($urandom));
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
